// File: rtl/stage_execute_mc.sv
// stage_execute_mc -- execute (X) stage of the five-stage pipeline.
//
// Resolves single-cycle ALU ops, branches/jumps and MX/WX bypassing in the
// issue cycle. Signed mul/div run on an iterative radix-2 unit, one bit per
// cycle, and hold the front of the pipeline with `stall` until done.
// Arithmetic exceptions replace `o_out` with a status code for $rstatus.
//
// Build option: define EXEC_MULDIV_EN to build the mul/div FSM and iterative
// unit. Without it mul/div complete in one cycle as an unimplemented-op trap
// (code 4/5, write_exception=1) and `stall` is tied low.
//
// Ports:
//   clock, reset                 rising-edge clock, sync active-high reset
//   insn, in_valid, flush        X instruction, valid qualifier, squash
//   regfile_operandA/B           D/X latched operands
//   pc_out, pc_upper             PC+1 of X insn, upper bits for jump targets
//   mx_bypass_A/B, wx_bypass_A/B operand source selects (MX > WX > regfile)
//   o_xm_out, data_writeReg      bypass sources
//   o_out                        result / link / setx target / exception code
//   b_out                        bypassed operand B (store data)
//   take_branch                  conditional branch taken (bne/blt/bex)
//   j_took_branch                any control transfer
//   pc_in                        redirect target (0 when none)
//   write_exception              write o_out to $rstatus
//   out_valid                    X/M latch loads a valid instruction
//   stall                        freeze PC, F/D, D/X; X/M gets a bubble
module stage_execute_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      insn,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] regfile_operandA,
  input  logic [WIDTH-1:0] regfile_operandB,
  input  logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-28:0] pc_upper,
  input  logic             mx_bypass_A,
  input  logic             mx_bypass_B,
  input  logic             wx_bypass_A,
  input  logic             wx_bypass_B,
  input  logic [WIDTH-1:0] o_xm_out,
  input  logic [WIDTH-1:0] data_writeReg,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] b_out,
  output logic             take_branch,
  output logic             j_took_branch,
  output logic [WIDTH-1:0] pc_in,
  output logic             write_exception,
  output logic             out_valid,
  output logic             stall
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [WIDTH-1:0] CODE_ADD  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CODE_ADDI = WIDTH'(2);
  localparam logic [WIDTH-1:0] CODE_SUB  = WIDTH'(3);
  localparam logic [WIDTH-1:0] CODE_MUL  = WIDTH'(4);
  localparam logic [WIDTH-1:0] CODE_DIV  = WIDTH'(5);

  // ---------------------------------------------------------------- decode
  logic [4:0]       w_opcode;
  logic [4:0]       w_aluop;
  logic [4:0]       w_shamt;
  logic             w_is_r, w_is_j, w_is_bne, w_is_jal, w_is_jr;
  logic             w_is_blt, w_is_bex, w_is_setx;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_target;
  logic             w_go;

  assign w_opcode  = insn[31:27];
  assign w_aluop   = insn[6:2];
  assign w_shamt   = insn[11:7];
  assign w_is_r    = (w_opcode == OP_RTYPE);
  assign w_is_j    = (w_opcode == OP_J);
  assign w_is_bne  = (w_opcode == OP_BNE);
  assign w_is_jal  = (w_opcode == OP_JAL);
  assign w_is_jr   = (w_opcode == OP_JR);
  assign w_is_blt  = (w_opcode == OP_BLT);
  assign w_is_bex  = (w_opcode == OP_BEX);
  assign w_is_setx = (w_opcode == OP_SETX);
  assign w_imm     = {{(WIDTH-17){insn[16]}}, insn[16:0]};
  assign w_target  = {pc_upper, insn[26:0]};
  assign w_go      = in_valid & ~flush & ~reset;

  // -------------------------------------------------------------- operands
  logic [WIDTH-1:0] w_opA, w_opB;

  assign w_opA = mx_bypass_A ? o_xm_out : (wx_bypass_A ? data_writeReg : regfile_operandA);
  assign w_opB = mx_bypass_B ? o_xm_out : (wx_bypass_B ? data_writeReg : regfile_operandB);
  assign b_out = w_opB;

  // ------------------------------------------------------ single-cycle ALU
  logic [WIDTH-1:0] w_sum, w_diff, w_addr;
  logic             w_add_ovf, w_sub_ovf, w_addi_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_exc;
  logic [WIDTH-1:0] w_code;

  assign w_sum      = w_opA + w_opB;
  assign w_diff     = w_opA - w_opB;
  assign w_addr     = w_opA + w_imm;
  assign w_add_ovf  = (w_opA[WIDTH-1] == w_opB[WIDTH-1]) & (w_sum[WIDTH-1]  != w_opA[WIDTH-1]);
  assign w_sub_ovf  = (w_opA[WIDTH-1] != w_opB[WIDTH-1]) & (w_diff[WIDTH-1] != w_opA[WIDTH-1]);
  assign w_addi_ovf = (w_opA[WIDTH-1] == w_imm[WIDTH-1]) & (w_addr[WIDTH-1] != w_opA[WIDTH-1]);

  always_comb begin
    w_result = '0;
    w_exc    = 1'b0;
    w_code   = '0;
    if (w_is_r) begin
      case (w_aluop)
        ALU_ADD: begin
          w_result = w_sum;
          w_exc    = w_add_ovf;
          w_code   = CODE_ADD;
        end
        ALU_SUB: begin
          w_result = w_diff;
          w_exc    = w_sub_ovf;
          w_code   = CODE_SUB;
        end
        ALU_AND: w_result = w_opA & w_opB;
        ALU_OR:  w_result = w_opA | w_opB;
        ALU_SLL: w_result = w_opA << w_shamt;
        ALU_SRA: w_result = $signed(w_opA) >>> w_shamt;
`ifndef EXEC_MULDIV_EN
        // No multiply/divide hardware: trap so software can emulate.
        ALU_MUL: begin
          w_exc  = 1'b1;
          w_code = CODE_MUL;
        end
        ALU_DIV: begin
          w_exc  = 1'b1;
          w_code = CODE_DIV;
        end
`endif
        default: w_result = '0;
      endcase
    end else begin
      case (w_opcode)
        OP_ADDI: begin
          w_result = w_addr;
          w_exc    = w_addi_ovf;
          w_code   = CODE_ADDI;
        end
        OP_LW, OP_SW: w_result = w_addr;
        default:      w_result = '0;
      endcase
    end
  end

  // ------------------------------------------------- branch / redirect
  logic w_bne_taken, w_blt_taken, w_bex_taken;

  assign w_bne_taken = w_is_bne & (w_opA != w_opB);
  assign w_blt_taken = w_is_blt & ($signed(w_opB) < $signed(w_opA));
  assign w_bex_taken = w_is_bex & (w_opA != '0);

  assign take_branch   = w_go & (w_bne_taken | w_blt_taken | w_bex_taken);
  assign j_took_branch = w_go & (w_is_j | w_is_jal | w_is_jr |
                                 w_bne_taken | w_blt_taken | w_bex_taken);

  always_comb begin
    pc_in = '0;
    if (w_go) begin
      if (w_is_j | w_is_jal | w_bex_taken)
        pc_in = w_target;
      else if (w_bne_taken | w_blt_taken)
        pc_in = pc_out + w_imm;
      else if (w_is_jr)
        pc_in = w_opB;
    end
  end

  // ------------------------------------------------------ mul/div unit
  logic             w_is_md;
  logic             w_md_issue;
  logic             w_md_busy;
  logic             w_md_done;
  logic             w_md_is_div;
  logic [WIDTH-1:0] w_md_res;
  logic             w_md_exc;
  logic             w_unused;

`ifdef EXEC_MULDIV_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;      // mul: upper product half; div: remainder
  logic [WIDTH-1:0] r_lo;      // mul: lower product / multiplier; div: dividend -> quotient
  logic [WIDTH-1:0] r_mcand;   // |B|: multiplicand or divisor
  logic             r_is_div;
  logic             r_neg;     // result sign, applied after magnitude iteration
  logic             r_div_exc;

  logic [WIDTH-1:0]   w_absA, w_absB;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_div_fits;
  logic [2*WIDTH-1:0] w_pmag, w_prod;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quot;

  assign w_is_md    = w_is_r & ((w_aluop == ALU_MUL) | (w_aluop == ALU_DIV));
  assign w_md_issue = (r_state == S_IDLE) & in_valid & w_is_md & ~flush;
  assign w_md_busy  = (r_state == S_BUSY);
  assign w_md_done  = (r_state == S_DONE);
  assign w_md_is_div = r_is_div;

  assign w_absA = w_opA[WIDTH-1] ? -w_opA : w_opA;
  assign w_absB = w_opB[WIDTH-1] ? -w_opB : w_opB;

  // Shift-add multiply: product grows into r_hi while the multiplier drains
  // out of the bottom of r_lo.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

  // Restoring divide: remainder never exceeds the divisor, so WIDTH+1 bits
  // cover the shifted partial remainder.
  assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_div_fits = (w_rem_sh >= {1'b0, r_mcand});
  assign w_rem_sub  = w_rem_sh - {1'b0, r_mcand};

  assign w_pmag    = {r_hi, r_lo};
  assign w_prod    = r_neg ? -w_pmag : w_pmag;
  assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign w_quot    = r_neg ? -r_lo : r_lo;

  assign w_md_res = r_is_div ? w_quot : w_prod[WIDTH-1:0];
  assign w_md_exc = r_is_div ? r_div_exc : w_mul_ovf;
  assign w_unused = &{1'b0, w_rem_sub[WIDTH]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_div_exc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_issue) begin
            r_state   <= S_BUSY;
            r_count   <= CW'(WIDTH - 1);
            r_hi      <= '0;
            r_lo      <= w_absA;
            r_mcand   <= w_absB;
            r_is_div  <= (w_aluop == ALU_DIV);
            r_neg     <= w_opA[WIDTH-1] ^ w_opB[WIDTH-1];
            r_div_exc <= (w_opB == '0) | ((w_opA == MIN_NEG) & (w_opB == '1));
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_hi <= w_div_fits ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_div_fits};
            end else begin
              r_hi <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
            if (r_count == '0)
              r_state <= S_DONE;
            else
              r_count <= r_count - CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_is_md     = 1'b0;
  assign w_md_issue  = 1'b0;
  assign w_md_busy   = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_is_div = 1'b0;
  assign w_md_res    = '0;
  assign w_md_exc    = 1'b0;
  assign w_unused    = &{1'b0, clock};
`endif

  // ------------------------------------------------------------ outputs
  assign stall = ~reset & ~flush & (w_md_issue | w_md_busy);

  // The DONE cycle still presents the mul/div insn, so only the MD path
  // may raise out_valid there.
  assign out_valid = ~reset & ~flush &
                     (w_md_done | (in_valid & ~w_is_md & ~w_md_busy));

  assign write_exception = w_md_done ? (w_md_exc & ~flush & ~reset) : (w_go & w_exc);

  always_comb begin
    o_out = w_result;
    if (w_md_done)
      o_out = w_md_exc ? (w_md_is_div ? CODE_DIV : CODE_MUL) : w_md_res;
    else if (w_is_jal)
      o_out = pc_out;
    else if (w_exc)
      o_out = w_code;
    else if (w_is_setx)
      o_out = w_target;
  end

endmodule
